// File: rtl/flash_boot_server_pkg.sv
// Shared types and constants for the SPI NOR boot loader (flash_boot_server).
package flash_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_e;

    localparam logic [7:0] SPI_READ_CMD = 8'h03;
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_BITS    = 24;
    localparam int         WORD_BITS    = 16;

endpackage

// File: rtl/flash_boot_server_spi_shift_engine.sv
// SPI mode-0 shifter: SCK divider, MSB-first TX of up to 32 bits, 16-bit RX.
// Back-to-back fields keep SCK running: the next field is loaded on the trailing falling edge.
module spi_shift_engine #(
    parameter int SCK_DIV = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        more,
    input  logic [4:0]  nbits,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic [15:0] rx_data,
    output logic        done,
    output logic        fin
);

    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [30:0]   tx_sr;
    logic [4:0]    bit_cnt;
    logic          active;
    logic          last;
    logic          tick;

    assign tick = active && (div_cnt == DW'(SCK_DIV - 1));
    // done marks the rising edge that samples the last bit of a field;
    // fin marks the falling edge that closes the whole transfer.
    assign done = tick && !sck && (5'(bit_cnt + 5'd1) == nbits);
    assign fin  = tick && sck && last && !more;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_cnt <= '0;
            tx_sr   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            last    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            rx_data <= '0;
        end else if (start) begin
            div_cnt <= '0;
            tx_sr   <= tx_data[30:0];
            mosi    <= tx_data[31];
            bit_cnt <= '0;
            active  <= 1'b1;
            last    <= 1'b0;
            sck     <= 1'b0;
        end else if (active) begin
            div_cnt <= tick ? '0 : DW'(div_cnt + 1'b1);
            if (tick && !sck) begin
                sck     <= 1'b1;
                rx_data <= {rx_data[14:0], miso};
                bit_cnt <= 5'(bit_cnt + 5'd1);
                if (5'(bit_cnt + 5'd1) == nbits) begin
                    last <= 1'b1;
                end
            end else if (tick && sck) begin
                sck <= 1'b0;
                if (last) begin
                    last    <= 1'b0;
                    bit_cnt <= '0;
                    if (more) begin
                        tx_sr <= tx_data[30:0];
                        mosi  <= tx_data[31];
                    end else begin
                        active <= 1'b0;
                        mosi   <= 1'b0;
                    end
                end else begin
                    tx_sr <= {tx_sr[29:0], 1'b0};
                    mosi  <= tx_sr[30];
                end
            end
        end
    end

endmodule

// File: rtl/flash_boot_server.sv
// Boots a program image from SPI NOR flash into program RAM, then serves core fetches.
// Optional image checksum word: define FLASH_CHECKSUM_EN.
module flash_boot_server
    import flash_boot_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          PROG_WORDS = 4096,
    parameter int          SCK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [15:0]           flash_data,
    output logic                  flash_ready,
    output logic                  boot_err,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output boot_state_e           dbg_state
);

    localparam logic [ADDR_WIDTH:0] PROG_LIMIT = (ADDR_WIDTH + 1)'(PROG_WORDS);

    boot_state_e           state;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic                  start;
    logic                  more;
    logic [4:0]            nbits;
    logic [31:0]           tx_data;
    logic [15:0]           rx_data;
    logic                  done;
    logic                  fin;
    logic [15:0]           ram [2**ADDR_WIDTH];

`ifdef FLASH_CHECKSUM_EN
    logic [15:0] csum;
    logic        csum_got;
`else
    assign boot_err = 1'b0;
`endif

    assign dbg_state = state;

    // Field description of the current state; the engine latches it when a field starts.
    always_comb begin
        more    = 1'b0;
        nbits   = 5'(WORD_BITS);
        tx_data = '0;
        case (state)
            CMD:  begin
                nbits   = 5'(CMD_BITS);
                tx_data = {SPI_READ_CMD, 24'h0};
            end
            ADDR: begin
                nbits   = 5'(ADDR_BITS);
                tx_data = {FLASH_BASE, 8'h0};
                more    = 1'b1;
            end
            DATA: more = (word_cnt < PROG_LIMIT);
`ifdef FLASH_CHECKSUM_EN
            CSUM: more = !csum_got;
`endif
            default: more = 1'b0;
        endcase
    end

    spi_shift_engine #(.SCK_DIV(SCK_DIV)) u_spi (
        .clk     (clk),
        .arst_n  (arst_n),
        .start   (start),
        .more    (more),
        .nbits   (nbits),
        .tx_data (tx_data),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .rx_data (rx_data),
        .done    (done),
        .fin     (fin)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            spi_cs_n    <= 1'b1;
            flash_ready <= 1'b0;
            start       <= 1'b0;
            word_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
`ifdef FLASH_CHECKSUM_EN
            csum        <= '0;
            csum_got    <= 1'b0;
            boot_err    <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            wr_en <= 1'b0;
`ifdef FLASH_CHECKSUM_EN
            if (wr_en) csum <= csum + rx_data;
`endif
            case (state)
                IDLE: begin
                    state    <= CMD;
                    spi_cs_n <= 1'b0;
                    start    <= 1'b1;
                end
                CMD:  if (done) state <= ADDR;
                ADDR: if (done) state <= DATA;
                DATA: begin
                    if (done) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= word_cnt[ADDR_WIDTH-1:0];
                        word_cnt <= word_cnt + 1'b1;
`ifdef FLASH_CHECKSUM_EN
                        if (word_cnt + 1'b1 == PROG_LIMIT) state <= CSUM;
`endif
                    end
                    if (fin) begin
                        state       <= DONE;
                        spi_cs_n    <= 1'b1;
                        flash_ready <= 1'b1;
                    end
                end
`ifdef FLASH_CHECKSUM_EN
                CSUM: begin
                    if (done) csum_got <= 1'b1;
                    if (fin) begin
                        spi_cs_n <= 1'b1;
                        if (16'(csum + rx_data) == 16'h0000) begin
                            state       <= DONE;
                            flash_ready <= 1'b1;
                        end else begin
                            state    <= ERR;
                            boot_err <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= rx_data;
    end

    // Fetch: pc_in is sampled every clk; flash_data holds the word one clk later and is
    // only meaningful while flash_ready=1. Words outside the image read as zero.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            flash_data <= 16'h0000;
        end else begin
            flash_data <= (flash_ready && ({1'b0, pc_in} < PROG_LIMIT)) ? ram[pc_in] : 16'h0000;
        end
    end

endmodule

// File: tb/tb_flash_boot_server.sv
// Bench for flash_boot_server: SPI NOR flash model, fetch scoreboard, mode-0 protocol watch.
`timescale 1ns/1ps
module tb_flash_boot_server;
  import flash_boot_pkg::*;

  localparam int          AW = 3;
  localparam int          PW = 4;
  localparam int          SD = 1;
  localparam logic [23:0] FB = 24'h0;
`ifdef FLASH_CHECKSUM_EN
  localparam int NW = PW + 1;
`else
  localparam int NW = PW;
`endif
  localparam int BOOT_RISES = 32 + 16 * NW;

  logic          clk;
  logic          arst_n;
  logic [AW-1:0] pc_in;
  logic [15:0]   flash_data;
  logic          flash_ready;
  logic          boot_err;
  logic          spi_cs_n;
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_miso;
  boot_state_e   dbg_state;

  flash_boot_server #(.ADDR_WIDTH(AW), .PROG_WORDS(PW), .SCK_DIV(SD), .FLASH_BASE(FB)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .pc_in       (pc_in),
    .flash_data  (flash_data),
    .flash_ready (flash_ready),
    .boot_err    (boot_err),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters, reference image ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  flash_mem [0:15];
  bit          exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int addr);
    if (addr >= 0 && addr < 16) return flash_mem[addr];
    return 8'h00;
  endfunction

  function automatic logic [15:0] img_word(input int i);
    return {mem_byte(int'(FB) + 2 * i), mem_byte(int'(FB) + 2 * i + 1)};
  endfunction

  function automatic logic [15:0] model_read(input int a);
    if (!exp_ready || a >= PW) return 16'h0000;
    return img_word(a);
  endfunction

  // Image words are given explicitly or drawn at random; the trailing word makes the
  // 16-bit sum of all words zero, plus one when a corrupt checksum is wanted.
  task automatic set_image(input bit use_fixed, input bit bad_sum);
    logic [15:0] fixed_w [PW];
    logic [15:0] w;
    int          sum;
    fixed_w = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h8001};
    for (int i = 0; i < 16; i++) flash_mem[i] = 8'($urandom_range(0, 255));
    sum = 0;
    for (int i = 0; i < PW; i++) begin
      w = use_fixed ? fixed_w[i] : 16'($urandom_range(0, 65535));
      flash_mem[2 * i]     = w[15:8];
      flash_mem[2 * i + 1] = w[7:0];
      sum += int'(w);
    end
    w = 16'(65536 - (sum % 65536)) + (bad_sum ? 16'd1 : 16'd0);
    flash_mem[2 * PW]     = w[15:8];
    flash_mem[2 * PW + 1] = w[7:0];
  endtask

  // ---------------- SPI flash model ----------------
  int          rise_cnt;
  logic [31:0] cmd_sr;

  function automatic logic stream_bit(input int j);
    logic [15:0] w;
    int          wi;
    wi = j / 16;
    if (wi >= NW) return 1'b0;
    w = {mem_byte(int'(cmd_sr[23:0]) + 2 * wi), mem_byte(int'(cmd_sr[23:0]) + 2 * wi + 1)};
    return w[15 - (j % 16)];
  endfunction

  initial begin
    spi_miso = 1'b0;
    rise_cnt = 0;
    cmd_sr   = '0;
  end

  always @(negedge spi_cs_n) begin
    rise_cnt = 0;
    cmd_sr   = '0;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      if (rise_cnt < 32) cmd_sr = {cmd_sr[30:0], spi_mosi};
      rise_cnt++;
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && rise_cnt >= 32) spi_miso = stream_bit(rise_cnt - 32);
  end

  // ---------------- mode-0 protocol watch ----------------
  int   proto_viol;
  int   run_len;
  bit   run_ok;
  logic prev_sck;
  logic prev_mosi;

  initial begin
    proto_viol = 0;
    run_len    = 0;
    run_ok     = 0;
    prev_sck   = 1'b0;
    prev_mosi  = 1'b0;
  end

  always @(negedge clk) begin
    if (!arst_n || spi_cs_n) begin
      run_ok  = 0;
      run_len = 0;
    end else begin
      if (spi_sck && spi_mosi !== prev_mosi) proto_viol++;
      if (spi_sck !== prev_sck) begin
        if (run_ok && run_len != SD) proto_viol++;
        run_ok  = 1;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  end

  // ---------------- fetch driver + monitor ----------------
  logic req_v = 1'b0;
  logic mon_v = 1'b0;

  always @(posedge clk) mon_v <= req_v;

  always @(negedge clk) begin
    if (mon_v) begin
      if (exp_q.size() == 0) begin
        chk("fetch_unexpected", 32'(flash_data), 32'hdead_beef);
      end else begin
        chk("fetch_data", 32'(flash_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue_read(input int a);
    @(posedge clk);
    #1;
    pc_in = AW'(a);
    req_v = 1'b1;
    exp_q.push_back(model_read(a));
  endtask

  task automatic end_reads();
    int t;
    @(posedge clk);
    #1;
    req_v = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("fetch_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- boot sequence ----------------
  task automatic boot(input bit bad_sum, input int abort_at);
    int t;
    arst_n     = 1'b0;
    pc_in      = '0;
    req_v      = 1'b0;
    exp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_ready", 32'(flash_ready), 32'd0);
    chk("rst_data", 32'(flash_data), 32'd0);
    chk("rst_err", 32'(boot_err), 32'd0);
    proto_viol = 0;
    @(negedge clk);
    arst_n = 1'b1;

    for (int a = 0; a < PW; a++) issue_read(a);
    end_reads();

    t = 0;
    while (spi_cs_n && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("cs_fall", 32'(spi_cs_n), 32'd0);

    if (abort_at > 0) begin
      t = 0;
      while (rise_cnt < abort_at && t < 5000) begin
        @(posedge clk);
        t++;
      end
      chk("abort_reach", 32'(rise_cnt >= abort_at), 32'd1);
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
      chk("abort_ready", 32'(flash_ready), 32'd0);
      chk("abort_sck", 32'(spi_sck), 32'd0);
      return;
    end

    t = 0;
    while (!spi_cs_n && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("cs_rise", 32'(spi_cs_n), 32'd1);
    chk("ready_with_cs", 32'(flash_ready), 32'(!bad_sum));
    chk("boot_err", 32'(boot_err), 32'(bad_sum));
    chk("end_state", 32'(dbg_state), bad_sum ? 32'(ERR) : 32'(DONE));
    chk("cmd_addr", cmd_sr, {SPI_READ_CMD, FB});
    chk("sck_rises", 32'(rise_cnt), 32'(BOOT_RISES));
    chk("mode0_viol", 32'(proto_viol), 32'd0);

    exp_ready = !bad_sum;
    issue_read(1);
    issue_read(7);
    for (int i = 0; i < 16; i++) issue_read(int'($urandom_range(0, (1 << AW) - 1)));
    end_reads();
    chk("idle_cs_n", 32'(spi_cs_n), 32'd1);
    chk("idle_sck", 32'(spi_sck), 32'd0);
  endtask

  initial begin
    arst_n = 1'b0;
    pc_in  = '0;
    set_image(1'b1, 1'b0);
    boot(1'b0, 0);
    set_image(1'b0, 1'b0);
    boot(1'b0, 32 + 16 * 2 + 5);
    set_image(1'b0, 1'b0);
    boot(1'b0, 0);
    set_image(1'b0, 1'b0);
    boot(1'b0, 0);
`ifdef FLASH_CHECKSUM_EN
    set_image(1'b1, 1'b1);
    boot(1'b1, 0);
    set_image(1'b0, 1'b0);
    boot(1'b0, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
